// File: rtl/e_4_pkg.sv
// Shared types and constants for the e_4 parallel-in/serial-out transmitter.
package e_4_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam logic        START_BIT     = 1'b0;
    localparam logic        STOP_BIT      = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/e_4_fifo.sv
// Small synchronous word FIFO; a push into an empty FIFO that is popped in the
// same cycle passes straight through without being stored.
module e_4_fifo
    import e_4_pkg::*;
#(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1),
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata_c,
    output logic             o_full_c,
    output logic             o_empty_c,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [2**PW];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_bypass;
    logic             w_wr;
    logic             w_rd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full_c  = (r_count == CW'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign o_count   = r_count;
    assign w_bypass  = i_push && i_pop && o_empty_c;
    assign w_wr      = i_push && !o_full_c && !w_bypass;
    assign w_rd      = i_pop && !o_empty_c;
    assign o_rdata_c = o_empty_c ? i_wdata : r_mem[r_rd_ptr];

    // Word storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/e_4_piso_tx.sv
// Buffered parallel-in/serial-out transmitter: start bit, WIDTH data bits,
// stop bit, one bit per clock, frames back to back while words are queued.
module e_4_piso_tx
    import e_4_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned DEPTH     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pi,
    input  logic             pi_valid,
    output logic             pi_ready,
    output logic             so,
    output logic             so_frame,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_shift_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_so_nxt;
    logic             w_frame_nxt;
    logic             w_done_nxt;

    logic             w_push;
    logic             w_pop;
    logic             w_avail;
    logic [WIDTH-1:0] w_rdata;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic             w_head;
    logic [WIDTH-1:0] w_shifted;

    e_4_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .i_push    (w_push),
        .i_wdata   (pi),
        .i_pop     (w_pop),
        .o_rdata_c (w_rdata),
        .o_full_c  (w_full),
        .o_empty_c (w_empty),
        .o_count   (w_count)
    );

    // Ready is decoded directly so it drops the moment reset asserts.
    assign pi_ready  = rst && !w_full;
    assign w_push    = pi_valid && pi_ready;
    // A word arriving this cycle can start a frame immediately.
    assign w_avail   = !w_empty || w_push;
    assign w_head    = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    assign w_shifted = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};

    // Next state and next values of the serial outputs and shifter.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_shift_nxt  = r_shift;
        w_cnt_nxt    = r_cnt;
        w_so_nxt     = STOP_BIT;
        w_frame_nxt  = 1'b0;
        w_done_nxt   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_avail) begin
                    w_next_state = START;
                    w_pop        = 1'b1;
                    w_shift_nxt  = w_rdata;
                    w_so_nxt     = START_BIT;
                end
            end
            START: begin
                w_next_state = DATA;
                w_cnt_nxt    = '0;
                w_so_nxt     = w_head;
                w_frame_nxt  = 1'b1;
                w_shift_nxt  = w_shifted;
            end
            DATA: begin
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_next_state = STOP;
                    w_so_nxt     = STOP_BIT;
                    w_done_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_so_nxt    = w_head;
                    w_frame_nxt = 1'b1;
                    w_shift_nxt = w_shifted;
                end
            end
            STOP: begin
                if (w_avail) begin
                    w_next_state = START;
                    w_pop        = 1'b1;
                    w_shift_nxt  = w_rdata;
                    w_so_nxt     = START_BIT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State, shifter and registered line outputs; reset aborts any frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            so       <= STOP_BIT;
            so_frame <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_shift  <= w_shift_nxt;
            r_cnt    <= w_cnt_nxt;
            so       <= w_so_nxt;
            so_frame <= w_frame_nxt;
            busy     <= (w_next_state != IDLE) || (w_count != '0);
            done     <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_e_4_piso_tx.sv
// Bench for e_4_piso_tx: two instances (MSB-first and LSB-first) share the
// stimulus; a frame-level model predicts every cycle, literals pin key cases.
module tb_e_4_piso_tx;

    localparam int unsigned W  = 4;
    localparam int unsigned D  = 2;
    localparam int          HN = 1024;
    localparam int          K_START = 0;
    localparam int          K_DATA  = 16;
    localparam int          K_STOP  = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] pi;
    logic         pi_valid;

    logic rdy_m, so_m, frm_m, bsy_m, dn_m;
    logic rdy_l, so_l, frm_l, bsy_l, dn_l;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    logic h_so_m [HN];
    logic h_so_l [HN];
    logic h_frm  [HN];
    logic h_dn   [HN];
    logic h_rdy  [HN];
    logic h_bsy  [HN];

    // Model state: words waiting in the buffer and the bits still to send.
    logic [W-1:0] mq [$];
    int           ml [$];
    logic [W-1:0] cur_w = '0;
    int           el;
    logic         e_so_m = 1'b1;
    logic         e_so_l = 1'b1;
    logic         e_frm  = 1'b0;
    logic         e_bsy  = 1'b0;
    logic         e_dn   = 1'b0;
    logic         e_rdy;

    e_4_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .DEPTH(D)) dut_m (
        .clk(clk), .rst(rst), .pi(pi), .pi_valid(pi_valid), .pi_ready(rdy_m),
        .so(so_m), .so_frame(frm_m), .busy(bsy_m), .done(dn_m)
    );

    e_4_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .DEPTH(D)) dut_l (
        .clk(clk), .rst(rst), .pi(pi), .pi_valid(pi_valid), .pi_ready(rdy_l),
        .so(so_l), .so_frame(frm_l), .busy(bsy_l), .done(dn_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: accept, queue, expand a word into start/data/stop.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            ml.delete();
            e_so_m = 1'b1; e_so_l = 1'b1; e_frm = 1'b0; e_bsy = 1'b0; e_dn = 1'b0;
        end else begin
            if (pi_valid === 1'b1 && mq.size() < int'(D)) mq.push_back(pi);
            if (ml.size() == 0 && mq.size() != 0) begin
                cur_w = mq.pop_front();
                ml.push_back(K_START);
                for (int i = 0; i < int'(W); i++) ml.push_back(K_DATA + i);
                ml.push_back(K_STOP);
            end
            e_frm = 1'b0;
            e_dn  = 1'b0;
            if (ml.size() != 0) begin
                el = ml.pop_front();
                if (el == K_START) begin
                    e_so_m = 1'b0; e_so_l = 1'b0;
                end else if (el == K_STOP) begin
                    e_so_m = 1'b1; e_so_l = 1'b1; e_dn = 1'b1;
                end else begin
                    e_so_m = cur_w[int'(W) - 1 - (el - K_DATA)];
                    e_so_l = cur_w[el - K_DATA];
                    e_frm  = 1'b1;
                end
                e_bsy = 1'b1;
            end else begin
                e_so_m = 1'b1; e_so_l = 1'b1;
                e_bsy  = (mq.size() != 0);
            end
        end
    end

    // Per-cycle comparison against the model and history capture.
    always @(negedge clk) begin
        if (cyc < HN) begin
            h_so_m[cyc] = so_m; h_so_l[cyc] = so_l; h_frm[cyc] = frm_m;
            h_dn[cyc] = dn_m; h_rdy[cyc] = rdy_m; h_bsy[cyc] = bsy_m;
        end
        cyc++;
        e_rdy = (rst === 1'b1) && (mq.size() < int'(D));
        chk("so_msb",     32'(so_m),  32'(e_so_m));
        chk("so_lsb",     32'(so_l),  32'(e_so_l));
        chk("frame_msb",  32'(frm_m), 32'(e_frm));
        chk("frame_lsb",  32'(frm_l), 32'(e_frm));
        chk("busy_msb",   32'(bsy_m), 32'(e_bsy));
        chk("busy_lsb",   32'(bsy_l), 32'(e_bsy));
        chk("done_msb",   32'(dn_m),  32'(e_dn));
        chk("done_lsb",   32'(dn_l),  32'(e_dn));
        chk("ready_msb",  32'(rdy_m), 32'(e_rdy));
        chk("ready_lsb",  32'(rdy_l), 32'(e_rdy));
    end

    // Literal check of n consecutive recorded cycles, first cycle in the MSB.
    task automatic seq_chk(input string name, input int sel, input int t0, input int n,
                           input logic [31:0] exp);
        logic [31:0] act;
        logic        b;
        act = '0;
        for (int i = 0; i < n; i++) begin
            case (sel)
                0:       b = h_so_m[t0 + i];
                1:       b = h_so_l[t0 + i];
                2:       b = h_frm[t0 + i];
                3:       b = h_dn[t0 + i];
                4:       b = h_rdy[t0 + i];
                default: b = h_bsy[t0 + i];
            endcase
            act = {act[30:0], b};
        end
        chk(name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push1(input logic [W-1:0] w);
        pi = w;
        pi_valid = 1'b1;
        tick();
        pi_valid = 1'b0;
        pi = ~w;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  t0;
        int  trel;
        bit  ok;
        rst = 1'b1;
        pi = '0;
        pi_valid = 1'b0;
        #1 rst = 1'b0;

        // Reset held for 5 cycles
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_outs_msb", 32'({so_m, frm_m, bsy_m, dn_m, rdy_m}), 32'(5'b10000));
        chk("reset_outs_lsb", 32'({so_l, frm_l, bsy_l, dn_l, rdy_l}), 32'(5'b10000));
        tick();
        rst = 1'b1;
        @(negedge clk); #1;
        chk("ready_after_release", 32'(rdy_m), 32'(1));

        // Single frame 1010, MSB first
        push1(4'b1010);
        t0 = cyc;
        settle(8);
        seq_chk("single_so",    0, t0, 6, 32'(6'b010101));
        seq_chk("single_frame", 2, t0, 6, 32'(6'b011110));
        seq_chk("single_done",  3, t0, 6, 32'(6'b000001));
        seq_chk("single_busy",  5, t0, 7, 32'(7'b1111110));
        seq_chk("single_idle",  0, t0 + 6, 2, 32'(2'b11));

        // Back-to-back 1010 then 1111
        pi = 4'b1010; pi_valid = 1'b1;
        tick();
        t0 = cyc;
        pi = 4'b1111;
        tick();
        pi_valid = 1'b0; pi = 4'b0000;
        settle(14);
        seq_chk("b2b_so",   0, t0, 12, 32'(12'b010101011111));
        seq_chk("b2b_done", 3, t0, 12, 32'(12'b000001000001));

        // LSB-first ordering of 0011
        push1(4'b0011);
        t0 = cyc;
        settle(8);
        seq_chk("lsb_so", 1, t0, 6, 32'(6'b011001));

        // Backpressure: three words back to back, fourth held until ready
        pi = 4'b0101; pi_valid = 1'b1;
        tick();
        t0 = cyc;
        pi = 4'b1111;
        tick();
        pi = 4'b1010;
        tick();
        pi = 4'b0110;
        ok = 1'b0;
        for (int n = 0; n < 30 && !ok; n++) begin
            @(negedge clk); #1;
            if (rdy_m) begin
                tick();
                ok = 1'b1;
            end
        end
        pi_valid = 1'b0; pi = 4'b0000;
        chk("bp_fourth_accepted", 32'(ok), 32'(1));
        settle(20);
        seq_chk("bp_ready", 4, t0, 7, 32'(7'b1100001));
        seq_chk("bp_so", 0, t0, 24, 32'(24'b001011011111010101001101));

        // Reset during the second data bit with one word buffered
        pi = 4'b1100; pi_valid = 1'b1;
        tick();
        t0 = cyc;
        pi = 4'b0011;
        tick();
        pi_valid = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk); #1;
        chk("abort_outs", 32'({so_m, bsy_m, dn_m, rdy_m}), 32'(4'b1000));
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        trel = cyc;
        settle(10);
        seq_chk("abort_so",        0, t0, 3, 32'(3'b011));
        seq_chk("abort_quiet_so",  0, trel, 10, 32'(10'h3FF));
        seq_chk("abort_quiet_bsy", 5, trel, 10, 32'(0));
        seq_chk("abort_no_done",   3, t0, 16, 32'(0));

        // Fresh frame after the aborted one
        push1(4'b0110);
        t0 = cyc;
        settle(8);
        seq_chk("post_abort_so", 0, t0, 6, 32'(6'b001101));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/e_4_piso_tx.md
E_4_PISO_TX -- requirements
Module: e_4_piso_tx

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the parallel word width in bits (legal range 2..16).
REQ-002 Parameter MSB_FIRST, default 1, SHALL select bit order: 1 sends pi[WIDTH-1] first, 0 sends pi[0] first.
REQ-003 Parameter DEPTH, default 2, SHALL set the input word-buffer depth in entries (legal values 1..4).
REQ-004 Port clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 Port rst  in  1  SHALL be the reset, asynchronous and active-low (0 = in reset).
REQ-006 Port pi  in  WIDTH  SHALL carry the parallel word, sampled when pi_valid and pi_ready are both 1 at a rising edge.
REQ-007 Port pi_valid  in  1  SHALL indicate pi holds a word to send.
REQ-008 Port pi_ready  out  1  SHALL indicate the buffer can accept a word this cycle.
REQ-009 Port so  out  1  SHALL be the registered serial line; it idles at 1.
REQ-010 Port so_frame  out  1  SHALL be 1 exactly in cycles where so carries a data bit.
REQ-011 Port busy  out  1  SHALL be 1 while a frame is on the line or the buffer is non-empty.
REQ-012 Port done  out  1  SHALL pulse 1 for one cycle, coincident with each stop bit.

Function
REQ-013 Each frame SHALL be: one start bit (0), WIDTH data bits, one stop bit (1); total WIDTH+2 cycles, one bit per clock.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP; transitions: IDLE->START when buffer non-empty; START->DATA; DATA->STOP after WIDTH bits; STOP->START if buffer non-empty, else STOP->IDLE.
REQ-015 A word SHALL be popped from the buffer on entry to START; its start bit SHALL appear on so the cycle after the accepting edge when IDLE with an empty buffer.
REQ-016 Back-to-back frames SHALL have no idle cycle between stop bit and next start bit.
REQ-017 A bit counter of ceil(log2(WIDTH)) bits SHALL count 0..WIDTH-1 in DATA and clear on entry to DATA.
REQ-018 pi_ready SHALL equal (buffer count < DEPTH) and SHALL be 0 while rst is low.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-020 pi_valid with pi_ready low SHALL be ignored; pi SHALL not be sampled.
REQ-021 Changes on pi during a frame SHALL not affect the frame in progress.

Reset
REQ-022 While rst is low: so=1, so_frame=0, busy=0, done=0, pi_ready=0, FSM=IDLE, counter=0, buffer empty.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously) and discard all buffered words; no done pulse for the aborted frame.
REQ-024 The first word SHALL be accepted no earlier than the first rising edge after rst deasserts.

Structure
REQ-025 Package e_4_pkg SHALL hold the FSM state typedef (IDLE, START, DATA, STOP) and constants START_BIT=0, STOP_BIT=1, default WIDTH=4.
REQ-026 Buffering SHALL be one sub-module e_4_fifo (synchronous, DEPTH entries, WIDTH bits, push/pop/full/empty/count); FSM, shifter and outputs stay in e_4_piso_tx.
REQ-027 All outputs SHALL be driven from registers except pi_ready, which SHALL be decoded from count and rst only.

Verification
REQ-028 Reset: hold rst=0 for 5 cycles -> so=1, so_frame=0, busy=0, done=0, pi_ready=0; release -> pi_ready=1 next cycle.
REQ-029 Single frame, MSB_FIRST=1: push 4'b1010 -> so = 0,1,0,1,0,1 over 6 cycles starting the cycle after acceptance; so_frame high on cycles 2-5; done on cycle 6; then so=1, busy=0.
REQ-030 Back-to-back: push 4'b1010 then 4'b1111 on consecutive cycles -> 12 contiguous cycles 0,1,0,1,0,1,0,1,1,1,1,1; two done pulses 6 cycles apart.
REQ-031 Backpressure, DEPTH=2: hold pi_valid with 4'b0101, 4'b1111, 4'b1010 -> first popped to START, buffer fills, pi_ready=0 until next pop; all three frames sent in order, no word lost or duplicated.
REQ-032 Bit order, MSB_FIRST=0: push 4'b0011 -> so = 0,1,1,0,0,1.
REQ-033 Reset mid-frame: assert rst on the 2nd data bit with one word buffered -> so=1 at once, no done; after release, no frame sent until a new push.
